// File: rtl/ft2232h_pkg.sv
// ft2232h_pkg
//   Shared definitions for the FT2232H synchronous-FIFO receive path:
//   the read FSM state encoding, the device data-bus width and the
//   OE#-to-RD# latency (one CLKOUT cycle of bus turnaround before the
//   first read strobe).
package ft2232h_pkg;

   localparam int BUS_W        = 8;
   localparam int OE_TO_RD_LAT = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OE   = 2'd1,
      ST_READ = 2'd2,
      ST_TURN = 2'd3
   } state_t;

endpackage

// File: rtl/ft2232h_rx_fifo.sv
// ft2232h_rx_fifo
//   Synchronous first-word-fall-through receive buffer.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, wdata       write request and byte
//     pop               read request (ignored while empty)
//     rdata             head byte, 8'h00 while empty
//     level             occupancy 0..DEPTH
//     full, empty       occupancy flags
//   Push and pop on the same edge both take effect, including when full.
module ft2232h_rx_fifo
   import ft2232h_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [BUS_W-1:0]           wdata,
   input  logic                       pop,
   output logic [BUS_W-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [BUS_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop on the same edge frees the slot, so a full buffer may still accept.
   assign do_push = push && (!full || do_pop);
   assign level   = count;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own;
   // the separate count distinguishes full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ft2232h_rx.sv
// ft2232h_rx
//   FT2232H synchronous-FIFO receive controller with an on-chip FWFT buffer.
//   Optional feature macro: FT2232H_RX_BYTE_COUNT_EN adds byte_count[31:0].
//   Ports:
//     clk         60 MHz CLKOUT from the device
//     rst_n       asynchronous active-low reset
//     rxf_n       RXF#, low while the device holds unread data
//     data_in     ADBUS, driven by the device while oe_n is low
//     oe_n, rd_n  OE# / RD#, registered
//     data_out    head byte of the buffer (first-word-fall-through)
//     data_valid  buffer non-empty
//     data_ready  consumer accept
//     level       buffer occupancy 0..DEPTH
//     fsm_state   current read FSM state, for observation
//     byte_count  bytes captured since reset (only with the macro)
//   Handshake: a byte leaves the buffer at every edge where data_valid and
//   data_ready are both high; data_out/data_valid are held until then.
module ft2232h_rx
   import ft2232h_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rxf_n,
   input  logic [BUS_W-1:0]       data_in,
   output logic                   oe_n,
   output logic                   rd_n,
   output logic [BUS_W-1:0]       data_out,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic [$clog2(DEPTH):0] level,
   output state_t                 fsm_state
`ifdef FT2232H_RX_BYTE_COUNT_EN
   ,
   output logic [31:0]            byte_count
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;

   state_t        state;
   state_t        next_state;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [LW-1:0] post_level;

   // A byte is on the bus and strobed whenever RD# is low and RXF# is low.
   assign push       = (state == ST_READ) && !rd_n && !rxf_n;
   assign pop        = data_valid && data_ready;
   assign data_valid = !empty;
   assign fsm_state  = state;

   // Occupancy after this edge; push only happens below DEPTH, so no wrap.
   assign post_level = level + LW'(push) - LW'(pop && !empty);

   ft2232h_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (data_in),
      .pop   (pop),
      .rdata (data_out),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (!rxf_n && !full) next_state = ST_OE;
         // OE# is low for OE_TO_RD_LAT cycle before RD# drops.
         ST_OE:   next_state = rxf_n ? ST_TURN : ST_READ;
         ST_READ: begin
            if (rxf_n || (post_level >= LW'(DEPTH))) next_state = ST_TURN;
         end
         ST_TURN: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Strobes are registered from next_state so they line up with state
   // and rxf_n never reaches rd_n combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         oe_n  <= 1'b1;
         rd_n  <= 1'b1;
      end else begin
         state <= next_state;
         oe_n  <= !((next_state == ST_OE) || (next_state == ST_READ));
         rd_n  <= (next_state != ST_READ);
      end
   end

`ifdef FT2232H_RX_BYTE_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_count <= '0;
      end else if (push) begin
         byte_count <= byte_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ft2232h_rx.sv
// tb_ft2232h_rx
//   Directed bench for ft2232h_rx (DEPTH=8) with a simple FT2232H device
//   model: a byte array, a read index and an availability limit.
//   Optional feature macro: FT2232H_RX_BYTE_COUNT_EN (byte_count checked).
module tb_ft2232h_rx;
   import ft2232h_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          rxf_n;
   logic [7:0]    data_in;
   logic          oe_n;
   logic          rd_n;
   logic [7:0]    data_out;
   logic          data_valid;
   logic          data_ready;
   logic [LW-1:0] level;
   state_t        fsm_state;
`ifdef FT2232H_RX_BYTE_COUNT_EN
   logic [31:0]   byte_count;
`endif

   ft2232h_rx #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxf_n      (rxf_n),
      .data_in    (data_in),
      .oe_n       (oe_n),
      .rd_n       (rd_n),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .level      (level),
      .fsm_state  (fsm_state)
`ifdef FT2232H_RX_BYTE_COUNT_EN
      ,
      .byte_count (byte_count)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // device model and scoreboard state
   logic [7:0] exp_q[$];
   logic [7:0] dev_mem[16];
   int         dev_idx;
   int         dev_avail;
   int         n_cap;
   int         bc_exp;
   int         n_vec;
   int         n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic update_dev();
      rxf_n   = (dev_idx >= dev_avail);
      data_in = dev_mem[dev_idx % 16];
   endtask

   // One clock: pre-edge values decide capture and pop, then advance the
   // device model and settle #1 after the edge.
   task automatic tick();
      logic cap;
      logic pp;
      cap = !rd_n && !rxf_n;
      pp  = data_valid && data_ready;
      if (pp) begin
         if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
         else                   check("pop_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      if (cap) exp_q.push_back(data_in);
      @(posedge clk);
      #1;
      if (cap) begin
         dev_idx++;
         n_cap++;
         bc_exp++;
      end
      update_dev();
   endtask

   task automatic wait_state(input state_t s, input int max_cycles);
      for (int i = 0; i < max_cycles && fsm_state != s; i++) tick();
      check("wait_state", {30'd0, fsm_state}, {30'd0, s});
   endtask

   task automatic check_count();
`ifdef FT2232H_RX_BYTE_COUNT_EN
      check("byte_count", byte_count, bc_exp);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; n_cap = 0; bc_exp = 0;
      dev_idx = 0; dev_avail = 0;
      for (int i = 0; i < 16; i++) dev_mem[i] = 8'h00;
      data_ready = 1'b0;
      rst_n = 1'b0;
      update_dev();
      #12;
      check("rst_oe_n", {31'd0, oe_n}, 32'd1);
      check("rst_rd_n", {31'd0, rd_n}, 32'd1);
      check("rst_level", {28'd0, level}, 32'd0);
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_data", {24'd0, data_out}, 32'd0);
      check("rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check_count();
      rst_n = 1'b1;

      // single byte A5
      dev_mem[0] = 8'hA5; dev_idx = 0; dev_avail = 1; n_cap = 0;
      update_dev();
      tick();
      check("sb_state_oe", {30'd0, fsm_state}, {30'd0, ST_OE});
      check("sb_oe_n", {31'd0, oe_n}, 32'd0);
      check("sb_rd_n_oe", {31'd0, rd_n}, 32'd1);
      tick();
      check("sb_state_read", {30'd0, fsm_state}, {30'd0, ST_READ});
      check("sb_rd_n_read", {31'd0, rd_n}, 32'd0);
      tick();
      check("sb_level", {28'd0, level}, 32'd1);
      check("sb_valid", {31'd0, data_valid}, 32'd1);
      check("sb_data", {24'd0, data_out}, 32'hA5);
      tick();
      check("sb_state_turn", {30'd0, fsm_state}, {30'd0, ST_TURN});
      check("sb_rd_n_turn", {31'd0, rd_n}, 32'd1);
      check("sb_oe_n_turn", {31'd0, oe_n}, 32'd1);
      tick();
      check("sb_state_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check("sb_caps", n_cap, 32'd1);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("sb_drained", {28'd0, level}, 32'd0);
      check("sb_valid_0", {31'd0, data_valid}, 32'd0);
      // pop while empty is ignored
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("empty_pop_level", {28'd0, level}, 32'd0);
      check("empty_pop_data", {24'd0, data_out}, 32'd0);

      // burst into a full buffer: 10 bytes offered, 8 taken
      for (int i = 0; i < 10; i++) dev_mem[i] = 8'(i);
      dev_idx = 0; dev_avail = 10; n_cap = 0;
      update_dev();
      repeat (20) tick();
      check("full_caps", n_cap, 32'd8);
      check("full_level", {28'd0, level}, 32'd8);
      check("full_head", {24'd0, data_out}, 32'h00);
      check("full_rd_n", {31'd0, rd_n}, 32'd1);
      check("full_oe_n", {31'd0, oe_n}, 32'd1);
      check("full_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check_count();

      // drain 3, burst resumes with 08
      data_ready = 1'b1;
      repeat (3) tick();
      data_ready = 1'b0;
      check("resume_level", {28'd0, level}, 32'd5);
      check("resume_state", {30'd0, fsm_state}, {30'd0, ST_READ});
      check("resume_data_in", {24'd0, data_in}, 32'h08);
      tick();
      check("resume_cap_level", {28'd0, level}, 32'd6);
      check("resume_idx", dev_idx, 32'd9);
      repeat (3) tick();
      check("resume_end_level", {28'd0, level}, 32'd7);
      check("resume_end_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      data_ready = 1'b1;
      repeat (8) tick();
      data_ready = 1'b0;
      check("resume_drain", {28'd0, level}, 32'd0);
      check("resume_q_empty", exp_q.size(), 32'd0);

      // early end after 11,22,33
      dev_mem[0] = 8'h11; dev_mem[1] = 8'h22; dev_mem[2] = 8'h33;
      dev_idx = 0; dev_avail = 3; n_cap = 0;
      update_dev();
      wait_state(ST_TURN, 20);
      check("early_caps", n_cap, 32'd3);
      check("early_level", {28'd0, level}, 32'd3);
      check("early_turn_oe_n", {31'd0, oe_n}, 32'd1);
      check("early_turn_rd_n", {31'd0, rd_n}, 32'd1);
      tick();
      check("early_idle", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check("early_idle_oe_n", {31'd0, oe_n}, 32'd1);
      data_ready = 1'b1;
      repeat (4) tick();
      data_ready = 1'b0;
      check("early_drain", {28'd0, level}, 32'd0);

      // push and pop together during a 5-byte burst at level 4
      for (int i = 0; i < 9; i++) dev_mem[i] = 8'h40 + 8'(i);
      dev_idx = 0; dev_avail = 4; n_cap = 0;
      update_dev();
      repeat (12) tick();
      check("sim_pre_level", {28'd0, level}, 32'd4);
      check("sim_pre_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      dev_avail = 9;
      update_dev();
      wait_state(ST_READ, 10);
      data_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("sim_level", {28'd0, level}, 32'd4);
      end
      repeat (7) tick();
      data_ready = 1'b0;
      check("sim_caps", n_cap, 32'd9);
      check("sim_drain", {28'd0, level}, 32'd0);
      check("sim_q_empty", exp_q.size(), 32'd0);
      check_count();

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 8; i++) dev_mem[i] = 8'hC0 + 8'(i);
      dev_idx = 0; dev_avail = 8; n_cap = 0;
      update_dev();
      wait_state(ST_READ, 10);
      tick();
      tick();
      check_count();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_oe_n", {31'd0, oe_n}, 32'd1);
      check("arst_rd_n", {31'd0, rd_n}, 32'd1);
      check("arst_level", {28'd0, level}, 32'd0);
      check("arst_valid", {31'd0, data_valid}, 32'd0);
      check("arst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      bc_exp = 0;
      check_count();
      exp_q.delete();
      dev_avail = dev_idx;
      update_dev();
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
      check("post_rst_level", {28'd0, level}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
